// File: rtl/tfc_conflict_monitor_if.sv
// Light-code inputs and lamp/fault outputs of the conflict monitor.
interface tfc_conflict_monitor_if;
    logic [1:0] ns_code;
    logic [1:0] ew_code;
    logic       clr_fault;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic       fault;
    logic [2:0] fault_cause;

    modport master (
        output ns_code, ew_code, clr_fault,
        input  ns_lamp, ew_lamp, fault, fault_cause
    );

    modport slave (
        input  ns_code, ew_code, clr_fault,
        output ns_lamp, ew_lamp, fault, fault_cause
    );
endinterface

// File: rtl/tfc_conflict_monitor.sv
// Safety stage for the two-way light controller: checks each sample for
// conflicts, illegal sequences, short yellows and stuck outputs, drives
// one-hot lamps, and falls back to flashing red on any violation.
module tfc_conflict_monitor #(
    parameter int MIN_YEL    = 2,
    parameter int MAX_HOLD   = 32,
    parameter int FLASH_HALF = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tfc_conflict_monitor_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int YW = $clog2(MIN_YEL + 1);

    localparam logic [1:0] C_R = 2'b00;
    localparam logic [1:0] C_Y = 2'b01;
    localparam logic [1:0] C_G = 2'b10;
    localparam logic [2:0] L_RED = 3'b100;

    typedef enum logic {RUN, FAULT} mode_t;

    mode_t          mode_q, mode_d;
    logic [1:0]     prev_ns_q, prev_ns_d, prev_ew_q, prev_ew_d;
    logic [YW-1:0]  yel_ns_q, yel_ns_d, yel_ew_q, yel_ew_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [FW-1:0]  flash_cnt_q, flash_cnt_d;
    logic           flash_on_q, flash_on_d;
    logic [2:0]     ns_lamp_q, ns_lamp_d, ew_lamp_q, ew_lamp_d;
    logic [2:0]     cause_q, cause_d;

    function automatic logic [2:0] decode(input logic [1:0] c);
        case (c)
            C_Y:     decode = 3'b010;
            C_G:     decode = 3'b001;
            default: decode = L_RED;   // invalid never reaches here in RUN
        endcase
    endfunction

    // Only the listed per-side transitions are legal; Y->R also needs a full yellow.
    function automatic logic legal(input logic [1:0] p, input logic [1:0] c,
                                   input logic [YW-1:0] y);
        case ({p, c})
            {C_R, C_R}, {C_R, C_G}, {C_G, C_G},
            {C_G, C_Y}, {C_Y, C_Y}: legal = 1'b1;
            {C_Y, C_R}:             legal = (y >= YW'(MIN_YEL));
            default:                legal = 1'b0;
        endcase
    endfunction

    // Consecutive yellow samples, saturating at MIN_YEL.
    function automatic logic [YW-1:0] yel_next(input logic [1:0] p, input logic [1:0] c,
                                               input logic [YW-1:0] y);
        if (c != C_Y)               yel_next = '0;
        else if (p != C_Y)          yel_next = YW'(1);
        else if (y == YW'(MIN_YEL)) yel_next = y;
        else                        yel_next = y + YW'(1);
    endfunction

    logic          conflict, seq_err, stuck, same;
    logic [HW-1:0] hold_inc;
    logic [2:0]    viol;

    // Violation checks on the current sample against the previous one.
    always_comb begin
        conflict = (bus.ns_code == 2'b11) || (bus.ew_code == 2'b11) ||
                   ((bus.ns_code != C_R) && (bus.ew_code != C_R));
        seq_err  = !legal(prev_ns_q, bus.ns_code, yel_ns_q) ||
                   !legal(prev_ew_q, bus.ew_code, yel_ew_q);
        same     = (bus.ns_code == prev_ns_q) && (bus.ew_code == prev_ew_q);
        hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);
        stuck    = same && (hold_inc == HW'(MAX_HOLD));
        viol     = {stuck, seq_err, conflict};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= RUN;
            prev_ns_q   <= C_R;
            prev_ew_q   <= C_R;
            yel_ns_q    <= '0;
            yel_ew_q    <= '0;
            hold_q      <= '0;
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b0;
            ns_lamp_q   <= L_RED;
            ew_lamp_q   <= L_RED;
            cause_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            prev_ns_q   <= prev_ns_d;
            prev_ew_q   <= prev_ew_d;
            yel_ns_q    <= yel_ns_d;
            yel_ew_q    <= yel_ew_d;
            hold_q      <= hold_d;
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            ns_lamp_q   <= ns_lamp_d;
            ew_lamp_q   <= ew_lamp_d;
            cause_q     <= cause_d;
        end
    end

    // Mode transitions, counters and lamp selection.
    always_comb begin
        mode_d      = mode_q;
        prev_ns_d   = bus.ns_code;   // prev tracks inputs in both modes
        prev_ew_d   = bus.ew_code;
        yel_ns_d    = yel_ns_q;
        yel_ew_d    = yel_ew_q;
        hold_d      = hold_q;
        flash_cnt_d = flash_cnt_q;
        flash_on_d  = flash_on_q;
        ns_lamp_d   = ns_lamp_q;
        ew_lamp_d   = ew_lamp_q;
        cause_d     = cause_q;
        case (mode_q)
            RUN: begin
                if (|viol) begin
                    mode_d      = FAULT;
                    cause_d     = cause_q | viol;
                    ns_lamp_d   = L_RED;
                    ew_lamp_d   = L_RED;
                    flash_cnt_d = '0;
                    flash_on_d  = 1'b1;
                    hold_d      = '0;
                    yel_ns_d    = '0;
                    yel_ew_d    = '0;
                end else begin
                    ns_lamp_d = decode(bus.ns_code);
                    ew_lamp_d = decode(bus.ew_code);
                    yel_ns_d  = yel_next(prev_ns_q, bus.ns_code, yel_ns_q);
                    yel_ew_d  = yel_next(prev_ew_q, bus.ew_code, yel_ew_q);
                    hold_d    = same ? hold_inc : '0;
                end
            end
            FAULT: begin
                if (bus.clr_fault && !conflict) begin
                    mode_d    = RUN;
                    cause_d   = '0;
                    ns_lamp_d = decode(bus.ns_code);
                    ew_lamp_d = decode(bus.ew_code);
                    hold_d    = '0;
                    yel_ns_d  = '0;
                    yel_ew_d  = '0;
                end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
                    flash_cnt_d = '0;
                    flash_on_d  = !flash_on_q;
                end else begin
                    flash_cnt_d = flash_cnt_q + FW'(1);
                end
            end
            default: mode_d = RUN;
        endcase
    end

    assign bus.fault       = (mode_q == FAULT);
    assign bus.fault_cause = cause_q;
    assign bus.ns_lamp     = (mode_q == FAULT) ? (flash_on_q ? L_RED : 3'b000) : ns_lamp_q;
    assign bus.ew_lamp     = (mode_q == FAULT) ? (flash_on_q ? L_RED : 3'b000) : ew_lamp_q;
endmodule

// File: tb/tb_tfc_conflict_monitor.sv
// Directed bench for tfc_conflict_monitor: the driver queues hand-derived
// expectations per cycle, a monitor pops and compares after each edge.
module tb_tfc_conflict_monitor;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tfc_conflict_monitor_if bus();

    tfc_conflict_monitor #(.MIN_YEL(2), .MAX_HOLD(32), .FLASH_HALF(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [9:0] exp_q[$];
    string      tag_q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [2:0] dec(input logic [1:0] c);
        case (c)
            2'b01:   return Y;
            2'b10:   return G;
            default: return R;
        endcase
    endfunction

    task automatic step(input logic [1:0] ns, input logic [1:0] ew, input logic clr,
                        input logic rst, input logic [2:0] ens, input logic [2:0] eew,
                        input logic ef, input logic [2:0] ec, input string tag);
        @(negedge clk);
        bus.ns_code   = ns;
        bus.ew_code   = ew;
        bus.clr_fault = clr;
        rst_n         = !rst;
        exp_q.push_back({ens, eew, ef, ec});
        tag_q.push_back(tag);
    endtask

    task automatic run(input logic [1:0] ns, input logic [1:0] ew, input int n, input string tag);
        repeat (n) step(ns, ew, 1'b0, 1'b0, dec(ns), dec(ew), 1'b0, 3'b000, tag);
    endtask

    task automatic fl(input logic [1:0] ns, input logic [1:0] ew, input int n,
                      input logic on, input logic [2:0] c, input string tag);
        repeat (n) step(ns, ew, 1'b0, 1'b0, on ? R : O, on ? R : O, 1'b1, c, tag);
    endtask

    // Monitor: one expected output per cycle, compared after the edge.
    initial begin
        logic [9:0] e, got;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                got = {bus.ns_lamp, bus.ew_lamp, bus.fault, bus.fault_cause};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL %s: got ns=%b ew=%b fault=%b cause=%b, want ns=%b ew=%b fault=%b cause=%b",
                             t, got[9:7], got[6:4], got[3], got[2:0], e[9:7], e[6:4], e[3], e[2:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ns_code   = 2'b00;
        bus.ew_code   = 2'b00;
        bus.clr_fault = 1'b0;

        step(2'b00, 2'b00, 0, 1, R, R, 0, 3'b000, "reset");
        repeat (2) begin
            run(2'b10, 2'b00, 11, "ns_green");
            run(2'b01, 2'b00, 11, "ns_yellow");
            run(2'b00, 2'b10, 11, "ew_green");
            run(2'b00, 2'b01, 11, "ew_yellow");
        end

        // 32 identical samples then a change: no stuck fault
        step(2'b00, 2'b00, 0, 1, R, R, 0, 3'b000, "reset_hold");
        run(2'b10, 2'b00, 32, "hold32");
        run(2'b01, 2'b00, 2, "hold_change");
        run(2'b00, 2'b00, 1, "hold_yel_red");

        // 33rd identical sample: stuck fault, then flash period 8
        step(2'b00, 2'b00, 0, 1, R, R, 0, 3'b000, "reset_stuck");
        run(2'b10, 2'b00, 32, "stuck_pre");
        step(2'b10, 2'b00, 0, 0, R, R, 1, 3'b100, "stuck_fire");
        fl(2'b10, 2'b00, 3, 1, 3'b100, "stuck_on");
        fl(2'b10, 2'b00, 4, 0, 3'b100, "stuck_off");
        fl(2'b10, 2'b00, 1, 1, 3'b100, "stuck_on2");

        // Conflict during NS green, then clear attempts
        step(2'b00, 2'b00, 0, 1, R, R, 0, 3'b000, "reset_conf");
        run(2'b10, 2'b00, 3, "conf_pre");
        step(2'b10, 2'b10, 0, 0, R, R, 1, 3'b001, "conflict");
        fl(2'b10, 2'b00, 3, 1, 3'b001, "conf_on");
        fl(2'b10, 2'b00, 4, 0, 3'b001, "conf_off");
        fl(2'b10, 2'b00, 2, 1, 3'b001, "conf_on2");
        repeat (2) step(2'b10, 2'b10, 1, 0, R, R, 1, 3'b001, "clr_ignored");
        step(2'b10, 2'b00, 1, 0, G, R, 0, 3'b000, "clr_ok");
        step(2'b10, 2'b00, 1, 0, G, R, 0, 3'b000, "clr_in_run");
        run(2'b01, 2'b00, 2, "yel2");
        run(2'b00, 2'b00, 1, "yel2_red");

        // Direct G->R
        run(2'b10, 2'b00, 1, "seq_g");
        step(2'b00, 2'b00, 0, 0, R, R, 1, 3'b010, "g_to_r");
        fl(2'b00, 2'b00, 3, 1, 3'b010, "seq_on");
        step(2'b00, 2'b00, 1, 0, R, R, 0, 3'b000, "clr_seq");

        // One-cycle yellow, then reset during flash-off
        run(2'b10, 2'b00, 1, "sy_g");
        run(2'b01, 2'b00, 1, "sy_y");
        step(2'b00, 2'b00, 0, 0, R, R, 1, 3'b010, "short_yel");
        fl(2'b00, 2'b00, 3, 1, 3'b010, "sy_on");
        fl(2'b00, 2'b00, 2, 0, 3'b010, "sy_off");
        step(2'b00, 2'b00, 0, 1, R, R, 0, 3'b000, "reset_mid_fault");
        run(2'b10, 2'b00, 11, "post_ns_green");
        run(2'b01, 2'b00, 11, "post_ns_yellow");
        run(2'b00, 2'b10, 11, "post_ew_green");
        run(2'b00, 2'b01, 11, "post_ew_yellow");

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tfc_conflict_monitor.md
# tfc_conflict_monitor

Downstream safety stage for the two-way traffic light controller. Each cycle it takes the NS/EW 2-bit light codes, checks them for conflicts, illegal sequences, short yellows and stuck outputs, and drives one-hot lamp outputs. On any violation it latches a fault and forces both approaches to flashing red until the fault is cleared.

## Interface
- MIN_YEL, 2: minimum consecutive cycles a side must show yellow before it may go red.
- MAX_HOLD, 32: cycles an unchanged {ns_code, ew_code} pair may persist before a stuck fault.
- FLASH_HALF, 4: cycles per half-period of the fault flash (red on, then red off).
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ns_code  in  2  NS light code: 00 red, 01 yellow, 10 green, 11 invalid.
- ew_code  in  2  EW light code, same encoding.
- clr_fault  in  1  request to leave fault mode (level, sampled each cycle).
- ns_lamp  out  3  NS lamp drive {R,Y,G}, one-hot or all-off.
- ew_lamp  out  3  EW lamp drive {R,Y,G}.
- fault  out  1  high while in FAULT mode.
- fault_cause  out  3  sticky cause bits: [0] conflict/invalid, [1] sequence, [2] stuck.

## Operation
- Two modes: RUN and FAULT.
- Registered state:
  - prev_ns and prev_ew (previous codes).
  - Per-side yellow counters, saturating at MIN_YEL.
  - hold_cnt, width clog2(MAX_HOLD+1), saturating.
  - Flash counter, width clog2(FLASH_HALF).
  - flash_on bit.
- Checks are evaluated every RUN cycle on the current inputs against the prev_* registers:
  - **Conflict/invalid (cause[0]):** either code is 11, or both codes are non-red.
  - **Sequence (cause[1]):** any per-side transition other than R→R, R→G, G→G, G→Y, Y→Y, Y→R. Also a Y→R transition whose yellow counter is below MIN_YEL.
  - **Stuck (cause[2]):** hold_cnt reaches MAX_HOLD. hold_cnt increments while the pair equals prev and resets to 0 on any change.
- **RUN, no violation:**
  - Lamps take the decode of the inputs: 00→100, 01→010, 10→001.
  - prev_* and counters update.
- **RUN, any violation:**
  - Mode goes to FAULT and fault=1.
  - Every violated cause bit is set (OR-ed if several fire together).
  - Both lamps go to 100. The offending codes are never displayed.
  - Flash counter goes to 0 and flash_on to 1.
- **FAULT:**
  - Both lamps show 100 when flash_on=1, else 000.
  - flash_on toggles every FLASH_HALF cycles.
  - Input checks are suspended, but prev_* keeps tracking the inputs.
- **Clear:**
  - clr_fault is honoured in FAULT only if the current inputs pass the conflict/invalid check.
  - On the next edge: RUN, fault=0, fault_cause=0, lamps take the decode of the inputs, hold_cnt=0, yellow counters=0.
  - clr_fault while the inputs still conflict is ignored.
  - clr_fault in RUN has no effect.

## Timing
- Reset (rst_n=0 at a rising edge):
  - Mode RUN.
  - ns_lamp=ew_lamp=100, fault=0, fault_cause=000.
  - prev_* = 00, all counters 0.
  - Reset takes effect from any mode, including mid-fault.
- Latency: input code to lamp output is 1 cycle, registered.
- Violation at edge t: fault=1 and red lamps are visible after edge t. Red stays on for cycles t..t+FLASH_HALF-1, then is off for the next FLASH_HALF cycles.
- Stuck: the fault fires on the edge where hold_cnt would reach MAX_HOLD, i.e. on the (MAX_HOLD+1)-th consecutive identical sample. The counter saturates and never wraps.
- The yellow counter saturates at MIN_YEL. A Y→R transition is legal when the count is ≥ MIN_YEL.
- First sample after reset or clear is checked against prev_*:
  - After reset, prev_* = 00, so the first sample is checked against red.
  - After clear, prev_* holds the last inputs tracked during FAULT.

## Test plan
- Normal cycle: drive 10/00 (11 cyc), 01/00 (11), 00/10 (11), 00/01 (11), repeat twice → lamps 001/100, 010/100, 100/001, 100/010 each 1 cycle late; fault stays 0.
- Conflict: during NS green, drive ew_code=10 for one cycle → next edge fault=1, cause=001, lamps 100/100, then 000/000 after 4 cycles, period 8.
- Sequence errors:
  - NS 10→00 directly → cause=010.
  - Separately, NS yellow for 1 cycle then red (MIN_YEL=2) → cause=010.
  - 2 cycles of yellow then red → no fault.
- Stuck: hold 10/00 constant → fault at the 33rd identical sample, cause=100; 32 samples then a change → no fault.
- Clear: in FAULT with inputs 10/10, assert clr_fault → stays FAULT. Change to 10/00 with clr_fault=1 → next edge fault=0, cause=000, lamps 001/100.
- Reset mid-fault: rst_n=0 for one edge during a flash-off phase → lamps 100/100, fault=0, cause=000; normal cycle then resumes without fault.
